mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single-port instruction/data RAM between three requesters: instruction fetch (IMR phase), data load/store (DMRW phase) and the debug/loader port. It issues one transaction at a time and acknowledges each requester with a one-cycle pulse. It also produces the `imr_run` / `dmrw_run` busy flags that hold the CPU state machine in its memory phases. It sits between the CPU core, the debug loader and the RAM macro.

## Interface
- `AW`, 14: word address width.
- `RD_LAT`, 1: RAM read latency in cycles, legal range 1..3.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `imr_req`, `imr_addr`  in  1 / AW  fetch read request and word address.
- `imr_ack`  out  1  one-cycle completion pulse; `rdata` is valid in the same cycle.
- `dm_req`, `dm_we`, `dm_be`, `dm_addr`, `dm_wdata`  in  1/1/4/AW/32  data-phase request.
- `dm_ack`  out  1  completion pulse.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/AW/32  loader request; writes always use `be=4'hF`.
- `dbg_ack`  out  1  completion pulse.
- `rdata`  out  32  shared read data, valid only while an ack is high.
- `imr_run`, `dmrw_run`  out  1  `req & ~ack` for the fetch and data requesters.
- `dbg_busy`  out  1  high while a debug transaction is granted.
- `mem_ce`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`  out  1/1/4/AW/32  registered RAM controls.
- `mem_rdata`  in  32  RAM read data, valid RD_LAT cycles after a read with `mem_ce` high.

## Operation
- States:
  - ARB_IDLE: sample requests and pick a winner.
  - ARB_ISSUE: `mem_ce=1` for exactly one cycle.
  - ARB_WAIT: reads only; count RD_LAT-1 cycles.
  - ARB_DONE: drive the winner's ack and `rdata` from the capture register.
- Transitions:
  - IDLE goes to ISSUE when any request is high.
  - ISSUE goes to DONE on a write, or on a read when RD_LAT=1; otherwise it goes to WAIT.
  - WAIT goes to DONE when the counter expires.
  - DONE always returns to IDLE.
- Priority: dbg > dm > imr.
- Fairness rule: if the previous grant was dbg and `dm_req` or `imr_req` is high, the CPU requester wins. dbg never takes two consecutive grants while the CPU is waiting.
- Requests, address, `we`, `be` and `wdata` are latched into the grant registers on IDLE to ISSUE. Changes to them afterwards are ignored.
- Requester protocol:
  - Hold `req` and all fields stable until ack.
  - Drop `req` the cycle after ack.
  - If `req` drops before ack (a protocol violation), the transaction still completes and ack still pulses.
- The DONE state ignores all requests, so there is at least one IDLE cycle between transactions.
- `rdata` is 0 when no ack is high. Write acks also drive `rdata=0`.
- Read capture: `mem_rdata` is registered in the cycle it becomes valid and presented in DONE.
- Wait counter width is `$clog2(RD_LAT)`, with a minimum of 1 bit.

## Timing
- A request seen in IDLE at cycle N gives `mem_ce` high in cycle N+1.
- Write ack: cycle N+2.
- Read ack: cycle N+2+RD_LAT-1, i.e. N+2 for RD_LAT=1 and N+4 for RD_LAT=3.
- Back-to-back reads from one requester: one transaction per RD_LAT+2 cycles.
- Reset: when `rst_n` is low at a rising edge, all of the following take effect at that edge:
  - state goes to IDLE;
  - all outputs go to 0: `mem_ce`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, every ack, `rdata`, `dbg_busy`;
  - the last-grant flag is cleared (treated as "not dbg").
- Reset mid-transaction aborts the transaction with no ack. The RAM read that is already in flight is discarded.
- `imr_run` and `dmrw_run` are combinational from `req` and the registered ack. They drop in the ack cycle, so the CPU state machine advances at the following edge.

## Structure
- Shared package holds:
  - state encodings: ARB_IDLE=2'b00, ARB_ISSUE=2'b01, ARB_WAIT=2'b10, ARB_DONE=2'b11;
  - grant IDs: GNT_NONE, GNT_IMR, GNT_DM, GNT_DBG;
  - the full-word byte enable constant 4'hF.
- Single module. Priority and fairness stay inline; no sub-module is warranted.

## Test plan
- **Single fetch:** RD_LAT=1, `imr_req` with `imr_addr=0x010` and RAM word 0x00500093.
  - `mem_ce` high for one cycle with `mem_addr=0x010`.
  - `imr_ack` 2 cycles after the request with `rdata=0x00500093`.
  - `imr_run` is 1 until the ack cycle.
- **Data write:** `dm_req`, `dm_we=1`, `dm_be=4'b0011`, `dm_wdata=0xDEADBEEF`, `dm_addr=0x020`.
  - One-cycle `mem_ce` with `mem_we=1` and `mem_be=0011`.
  - `dm_ack` at N+2 with `rdata=0`.
- **Simultaneous requests:** dbg, dm and imr all raised in the same cycle and held.
  - Grant order is dbg, dm, dbg, imr.
  - No two consecutive dbg acks.
- **Read latency:** RD_LAT=3 read.
  - `mem_ce` at N+1, ack at N+4.
  - `rdata` equals the `mem_rdata` value sampled at N+4's capture edge.
- **Reset mid-transaction:** RD_LAT=3 read, `rst_n` low during the WAIT state.
  - No ack and all outputs 0 the next cycle.
  - A new `imr_req` after reset completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the RAM bus arbiter: FSM states, grant identifiers and
// the full-word byte enable.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE  = 2'b00;
  localparam logic [1:0] ARB_ISSUE = 2'b01;
  localparam logic [1:0] ARB_WAIT  = 2'b10;
  localparam logic [1:0] ARB_DONE  = 2'b11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMR  = 2'd1,
    GNT_DM   = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_t;

  localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter for instruction fetch, data load/store and the debug
// loader: one transaction at a time, one-cycle ack pulse per requester.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW     = 14,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          imr_req,
  input  logic [AW-1:0] imr_addr,
  output logic          imr_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [3:0]    dm_be,
  input  logic [AW-1:0] dm_addr,
  input  logic [31:0]   dm_wdata,
  output logic          dm_ack,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [31:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [31:0]   rdata,
  output logic          imr_run,
  output logic          dmrw_run,
  output logic          dbg_busy,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int            CW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((RD_LAT > 1) ? RD_LAT - 2 : 0);

  logic [1:0]    state;
  gnt_t          gnt;
  gnt_t          win;
  logic          gnt_we;
  logic          last_dbg;
  logic [CW-1:0] wait_cnt;
  logic          capture;

  // dbg yields to any waiting CPU requester right after its own grant.
  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    win = GNT_NONE;
    if (dbg_req && !(last_dbg && (dm_req || imr_req))) win = GNT_DBG;
    else if (dm_req)                                   win = GNT_DM;
    else if (imr_req)                                  win = GNT_IMR;
  end

  // The cycle in which read data is valid on mem_rdata (or the write is done).
  assign capture = (state == ARB_ISSUE && (gnt_we || RD_LAT == 1)) ||
                   (state == ARB_WAIT  && wait_cnt == '0);

  assign imr_run  = imr_req & ~imr_ack;
  assign dmrw_run = dm_req  & ~dm_ack;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers only control and output registers;
    // there is no storage array here that would need clearing.
    if (!rst_n) begin
      state     <= ARB_IDLE;
      gnt       <= GNT_NONE;
      gnt_we    <= 1'b0;
      last_dbg  <= 1'b0;
      wait_cnt  <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      imr_ack   <= 1'b0;
      dm_ack    <= 1'b0;
      dbg_ack   <= 1'b0;
      rdata     <= '0;
      dbg_busy  <= 1'b0;
    end else begin
      mem_ce <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (win != GNT_NONE) begin
            state    <= ARB_ISSUE;
            gnt      <= win;
            last_dbg <= (win == GNT_DBG);
            dbg_busy <= (win == GNT_DBG);
            mem_ce   <= 1'b1;
            case (win)
              GNT_DBG: begin
                gnt_we    <= dbg_we;
                mem_we    <= dbg_we;
                mem_be    <= BE_FULL;
                mem_addr  <= dbg_addr;
                mem_wdata <= dbg_wdata;
              end
              GNT_DM: begin
                gnt_we    <= dm_we;
                mem_we    <= dm_we;
                mem_be    <= dm_be;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
              end
              default: begin
                gnt_we    <= 1'b0;
                mem_we    <= 1'b0;
                mem_be    <= BE_FULL;
                mem_addr  <= imr_addr;
                mem_wdata <= '0;
              end
            endcase
          end
        end
        ARB_ISSUE: begin
          if (capture) begin
            state <= ARB_DONE;
          end else begin
            state    <= ARB_WAIT;
            wait_cnt <= WAIT_LOAD;
          end
        end
        ARB_WAIT: begin
          if (capture) state <= ARB_DONE;
          else         wait_cnt <= wait_cnt - 1'b1;
        end
        default: begin
          state    <= ARB_IDLE;
          imr_ack  <= 1'b0;
          dm_ack   <= 1'b0;
          dbg_ack  <= 1'b0;
          rdata    <= '0;
          dbg_busy <= 1'b0;
        end
      endcase

      if (capture) begin
        imr_ack <= (gnt == GNT_IMR);
        dm_ack  <= (gnt == GNT_DM);
        dbg_ack <= (gnt == GNT_DBG);
        rdata   <= gnt_we ? '0 : mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT=1 and RD_LAT=3) with RAM models;
// expected issues/acks are queued at stimulus time and checked by a monitor.
module tb_mem_bus_arbiter;

  localparam int AW = 14;
  localparam logic [2:0] W_IMR = 3'b001;
  localparam logic [2:0] W_DM  = 3'b010;
  localparam logic [2:0] W_DBG = 3'b100;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  logic          imr_req [2], dm_req [2], dm_we [2], dbg_req [2], dbg_we [2];
  logic [AW-1:0] imr_addr [2], dm_addr [2], dbg_addr [2];
  logic [3:0]    dm_be [2];
  logic [31:0]   dm_wdata [2], dbg_wdata [2];
  logic          imr_ack [2], dm_ack [2], dbg_ack [2];
  logic          imr_run [2], dmrw_run [2], dbg_busy [2];
  logic          mem_ce [2], mem_we [2];
  logic [3:0]    mem_be [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0]   mem_wdata [2], rdata [2];

  logic [31:0] ref_mem [2][64];

  typedef struct {
    int            k;
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [3:0]    be;
    logic [31:0]   wdata;
  } iss_t;

  typedef struct {
    int          k;
    int          cyc;
    logic [2:0]  who;
    logic [31:0] rdata;
  } ack_t;

  iss_t iss_q[$];
  ack_t ack_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(int i);
    if (i == 16) return 32'h0050_0093;
    return 32'h1357_0000 ^ (i * 32'h0001_0203);
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [31:0] ram [64];
    logic [31:0] head;
    logic [31:0] dly [2];
    logic [31:0] mrd;
    logic        init_done = 1'b0;

    mem_bus_arbiter #(.AW(AW), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .imr_req(imr_req[g]), .imr_addr(imr_addr[g]), .imr_ack(imr_ack[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_be(dm_be[g]),
      .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]), .dm_ack(dm_ack[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_ack(dbg_ack[g]),
      .rdata(rdata[g]), .imr_run(imr_run[g]), .dmrw_run(dmrw_run[g]),
      .dbg_busy(dbg_busy[g]), .mem_ce(mem_ce[g]), .mem_we(mem_we[g]),
      .mem_be(mem_be[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mrd)
    );

    // Read data must be sampled at the LAT-th edge after mem_ce is launched;
    // outside a read the bus carries junk so a mistimed capture shows up.
    assign head = (mem_ce[g] && !mem_we[g]) ? ram[mem_addr[g][5:0]]
                                            : {16'hA5A5, cyc[15:0]};
    assign mrd  = (LAT == 1) ? head : dly[1];

    always @(posedge clk) begin
      dly[0] <= head;
      dly[1] <= dly[0];
      if (!init_done) begin
        for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
        init_done <= 1'b1;
      end else if (mem_ce[g] && mem_we[g]) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[g][b]) ram[mem_addr[g][5:0]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected behaviour of one transaction whose request is sampled in IDLE at cycle c.
  task automatic push_exp(input int k, input logic [2:0] who, input logic we,
                          input logic [3:0] be, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input int c);
    iss_t       i;
    ack_t       a;
    logic       w;
    logic [3:0] eb;
    w  = (who == W_IMR) ? 1'b0 : we;
    eb = (who == W_DBG) ? 4'hF : be;
    i  = '{k: k, cyc: c + 1, addr: addr, we: w, be: eb, wdata: wdata};
    iss_q.push_back(i);
    a.k     = k;
    a.who   = who;
    a.cyc   = w ? c + 2 : c + 1 + lat_of(k);
    a.rdata = w ? 32'h0 : ref_mem[k][addr[5:0]];
    ack_q.push_back(a);
    if (w)
      for (int b = 0; b < 4; b++)
        if (eb[b]) ref_mem[k][addr[5:0]][8*b +: 8] = wdata[8*b +: 8];
  endtask

  function automatic logic ack_of(int k, logic [2:0] who);
    case (who)
      W_IMR:   return imr_ack[k];
      W_DM:    return dm_ack[k];
      default: return dbg_ack[k];
    endcase
  endfunction

  task automatic drive_req(input int k, input logic [2:0] who, input logic we,
                           input logic [3:0] be, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input int n_acks);
    int got = 0;
    case (who)
      W_IMR: begin imr_addr[k] = addr; imr_req[k] = 1'b1; end
      W_DM: begin
        dm_we[k] = we; dm_be[k] = be; dm_addr[k] = addr; dm_wdata[k] = wdata;
        dm_req[k] = 1'b1;
      end
      default: begin
        dbg_we[k] = we; dbg_addr[k] = addr; dbg_wdata[k] = wdata; dbg_req[k] = 1'b1;
      end
    endcase
    for (int t = 0; t < 40 && got < n_acks; t++) begin
      @(negedge clk);
      if (ack_of(k, who)) got++;
    end
    if (got < n_acks) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d who=%b: got %0d acks expected %0d", k, who, got, n_acks);
    end
    @(posedge clk); #1;
    case (who)
      W_IMR:   imr_req[k] = 1'b0;
      W_DM:    dm_req[k]  = 1'b0;
      default: dbg_req[k] = 1'b0;
    endcase
  endtask

  task automatic run_txn(input int k, input logic [2:0] who, input logic we,
                         input logic [3:0] be, input logic [AW-1:0] addr,
                         input logic [31:0] wdata);
    push_exp(k, who, we, be, addr, wdata, cyc);
    drive_req(k, who, we, be, addr, wdata, 1);
  endtask

  task automatic check_zero(input int k, input string tag);
    check($sformatf("%s_outputs_zero dut%0d", tag, k),
          {mem_ce[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k],
           imr_ack[k], dm_ack[k], dbg_ack[k], rdata[k], dbg_busy[k]}, '0);
  endtask

  task automatic monitor_one(input int k);
    iss_t       i;
    ack_t       a;
    logic [2:0] who;
    who = {dbg_ack[k], dm_ack[k], imr_ack[k]};
    if (mem_ce[k]) begin
      if (iss_q.size() == 0) begin
        check($sformatf("unexpected_mem_ce dut%0d", k), mem_ce[k], 1'b0);
      end else begin
        i = iss_q.pop_front();
        check($sformatf("issue_dut dut%0d", k), k, i.k);
        check($sformatf("issue_cycle dut%0d", k), cyc, i.cyc);
        check($sformatf("issue_addr dut%0d", k), mem_addr[k], i.addr);
        check($sformatf("issue_we dut%0d", k), mem_we[k], i.we);
        if (i.we) begin
          check($sformatf("issue_be dut%0d", k), mem_be[k], i.be);
          check($sformatf("issue_wdata dut%0d", k), mem_wdata[k], i.wdata);
        end
      end
    end
    if (who != 3'b000) begin
      if (ack_q.size() == 0) begin
        check($sformatf("unexpected_ack dut%0d", k), who, 3'b000);
      end else begin
        a = ack_q.pop_front();
        check($sformatf("ack_dut dut%0d", k), k, a.k);
        check($sformatf("ack_who dut%0d", k), who, a.who);
        check($sformatf("ack_cycle dut%0d", k), cyc, a.cyc);
        check($sformatf("ack_rdata dut%0d", k), rdata[k], a.rdata);
        if (a.who == W_DBG) check($sformatf("dbg_busy dut%0d", k), dbg_busy[k], 1'b1);
      end
    end else begin
      check($sformatf("idle_rdata dut%0d", k), rdata[k], 32'h0);
    end
    check($sformatf("imr_run dut%0d", k), imr_run[k], imr_req[k] && !imr_ack[k]);
    check($sformatf("dmrw_run dut%0d", k), dmrw_run[k], dm_req[k] && !dm_ack[k]);
  endtask

  always @(negedge clk)
    if (mon_en)
      for (int k = 0; k < 2; k++) monitor_one(k);

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    for (int k = 0; k < 2; k++) begin
      imr_req[k] = 0; dm_req[k] = 0; dm_we[k] = 0; dbg_req[k] = 0; dbg_we[k] = 0;
      imr_addr[k] = '0; dm_addr[k] = '0; dbg_addr[k] = '0; dm_be[k] = '0;
      dm_wdata[k] = '0; dbg_wdata[k] = '0;
      for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(i);
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_zero(k, "reset");
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Single fetch and byte-masked data write on RD_LAT=1.
    run_txn(0, W_IMR, 1'b0, 4'h0, 14'h010, 32'h0);
    run_txn(0, W_DM, 1'b1, 4'b0011, 14'h020, 32'hDEAD_BEEF);
    run_txn(0, W_DM, 1'b0, 4'hF, 14'h020, 32'h0);

    // All three requesters at once: order dbg, dm, dbg, imr.
    @(posedge clk); #1;
    c = cyc;
    push_exp(0, W_DBG, 1'b0, 4'hF, 14'h005, 32'h0, c);
    push_exp(0, W_DM,  1'b0, 4'hF, 14'h006, 32'h0, c + 3);
    push_exp(0, W_DBG, 1'b0, 4'hF, 14'h005, 32'h0, c + 6);
    push_exp(0, W_IMR, 1'b0, 4'hF, 14'h007, 32'h0, c + 9);
    fork
      drive_req(0, W_DBG, 1'b0, 4'hF, 14'h005, 32'h0, 2);
      drive_req(0, W_DM,  1'b0, 4'hF, 14'h006, 32'h0, 1);
      drive_req(0, W_IMR, 1'b0, 4'hF, 14'h007, 32'h0, 1);
    join

    // RD_LAT=3 reads, back to back.
    @(posedge clk); #1;
    run_txn(1, W_IMR, 1'b0, 4'h0, 14'h010, 32'h0);
    run_txn(1, W_DM, 1'b0, 4'hF, 14'h011, 32'h0);

    // Reset while waiting on RAM data: no ack, outputs cleared.
    repeat (2) @(posedge clk); #1;
    c = cyc;
    iss_q.push_back('{k: 1, cyc: c + 1, addr: 14'h00A, we: 1'b0, be: 4'hF, wdata: 32'h0});
    imr_addr[1] = 14'h00A; imr_req[1] = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0; imr_req[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero(1, "midreset");
    repeat (4) @(posedge clk); #1;
    run_txn(1, W_IMR, 1'b0, 4'h0, 14'h00B, 32'h0);

    // Request dropped before its ack still completes.
    @(posedge clk); #1;
    push_exp(1, W_IMR, 1'b0, 4'h0, 14'h00C, 32'h0, cyc);
    imr_addr[1] = 14'h00C; imr_req[1] = 1'b1;
    @(posedge clk); #1;
    imr_req[1] = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Random single-requester traffic on both latencies.
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 40; n++) begin
        logic [2:0] who;
        int         sel;
        sel = $urandom_range(0, 2);
        who = (sel == 0) ? W_IMR : (sel == 1) ? W_DM : W_DBG;
        run_txn(k, who, 1'($urandom), 4'($urandom), AW'($urandom), $urandom);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
    end

    repeat (8) @(posedge clk);
    @(negedge clk);
    check("issue_queue_drained", iss_q.size(), 0);
    check("ack_queue_drained", ack_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
